hex_entry: RTL
==============

Name: hex_entry

Overview:
- Upstream feeder for the 4-digit hex display.
- Consumes the received-byte stream from the terminal UART receiver and parses ASCII hex digits into a 16-bit edit buffer, with backspace, escape and inactivity timeout.
- Commits the buffer on Enter.
- Drives the 16-bit word the display shows: the live buffer while editing, otherwise the last committed value.

Parameters:
- TIMEOUT_CYCLES, 50000000, idle cycles in EDIT before an automatic abort; 0 disables the timeout.
- OVERWRITE, 1, on a 5th digit: 1 = shift it in and drop the oldest digit; 0 = reject it and flag an error.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  single-cycle strobe; rx_data is valid this cycle. Always accepted; no back-pressure.
- rx_data  in  8  received ASCII byte.
- word  out  16  display word: edit buffer in EDIT, committed value otherwise.
- value  out  16  last committed value.
- value_valid  out  1  one-cycle pulse when value updates.
- digit_count  out  3  digits in the edit buffer, 0..4.
- err  out  1  one-cycle pulse on a rejected byte.
- abort  out  1  one-cycle pulse on ESC or timeout abort.

Behaviour:
- Reset (async assert, sync release): state IDLE; edit, value and word 0; digit_count 0; all pulses 0; timeout counter 0.
- All outputs are registered and update the cycle after the rx_valid cycle. Cycles with rx_valid=0 change nothing except the timeout counter.
- States: IDLE, EDIT, CR_SEEN.
- Hex digit ('0'-'9', 'a'-'f', 'A'-'F'):
  - edit <= {edit[11:0], nib}; digit_count+1; state goes to EDIT.
  - From IDLE or CR_SEEN, edit starts from 0 before the shift.
  - At digit_count=4 with OVERWRITE=1: shift anyway; count stays 4.
  - At digit_count=4 with OVERWRITE=0: edit unchanged; err pulse.
- Backspace (0x08) or DEL (0x7F):
  - In EDIT: edit <= edit>>4; digit_count-1. If the count reaches 0, stay in EDIT showing 0000.
  - In IDLE or CR_SEEN: err pulse, no change.
- CR (0x0D) or LF (0x0A):
  - In EDIT with digit_count>0: value <= edit; value_valid pulse; edit and count cleared.
  - In EDIT with digit_count=0: return to IDLE, no commit, no err.
  - Next state is CR_SEEN for CR, IDLE for LF.
  - In CR_SEEN: LF is swallowed silently and goes to IDLE; any other byte is handled exactly as in IDLE.
  - In IDLE: CR/LF are ignored (blank line), no err.
- ESC (0x1B): in EDIT, clear edit and count, go to IDLE, abort pulse. Elsewhere ignored.
- Any other byte: err pulse; state and buffer unchanged.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter runs only in EDIT and is cleared by any rx_valid.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid: same effect as ESC (abort pulse); counter clears.
  - An rx_valid in that same cycle wins: the byte is processed and no abort occurs.
- word is IDLE/CR_SEEN ? value : edit. A commit therefore keeps the just-entered value visible.
- Counter width is $clog2(TIMEOUT_CYCLES+1); the timeout counter saturates and never wraps.
- Reset mid-edit discards the buffer and the committed value.

Decomposition:
- Package hex_entry_pkg: ASCII constants (BS, DEL, CR, LF, ESC) and the state enum {IDLE, EDIT, CR_SEEN}.
- Sub-module ascii_hex_decode: combinational; 8-bit char in, 4-bit nib plus is_hex out. Instantiated once.
- The top level holds the FSM, edit/value registers, digit counter and timeout counter.

Test Plan:
- Reset, then "1","a","F","3",CR -> value_valid pulse once, value=16'h1AF3, word=16'h1AF3, digit_count=0; a following LF produces no pulse and no err.
- "1","2","3","4","5" with OVERWRITE=1 -> word=16'h2345, count=4, no err. With OVERWRITE=0 -> word=16'h1234, one err pulse.
- "A","B",BS,"C",CR -> value=16'h00AC. BS in IDLE -> err pulse, value unchanged.
- Commit 16'h00AC, then "7",ESC -> abort pulse, word=16'h00AC, value unchanged, no value_valid.
- TIMEOUT_CYCLES=8, "5", then idle -> abort exactly 8 cycles after the byte's output update. A byte arriving on cycle 8 suppresses the abort.
- "G", 0x20, ESC in IDLE -> two err pulses, ESC silent. Assert rst mid-edit ("9","9") -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/hex_entry_pkg.sv
// Shared ASCII control codes and the line-editor state encoding.
package hex_entry_pkg;

    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_DEL = 8'h7F;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_ESC = 8'h1B;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EDIT    = 2'd1,
        CR_SEEN = 2'd2
    } state_t;

endpackage

// File: rtl/hex_entry_ascii_hex_decode.sv
// Maps an ASCII character to its hex nibble; is_hex flags 0-9, a-f, A-F.
module ascii_hex_decode (
    input  logic [7:0] ch,
    output logic [3:0] nib,
    output logic       is_hex
);

    always_comb begin
        nib    = 4'h0;
        is_hex = 1'b0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            nib    = 4'(ch - 8'h30);
            is_hex = 1'b1;
        end else if (ch >= 8'h61 && ch <= 8'h66) begin
            nib    = 4'(ch - 8'h57);
            is_hex = 1'b1;
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            nib    = 4'(ch - 8'h37);
            is_hex = 1'b1;
        end
    end

endmodule

// File: rtl/hex_entry.sv
// Line editor turning a UART byte stream into a committed 16-bit hex value
// and the word shown on the 4-digit display.
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter bit          OVERWRITE      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [15:0] word,
    output logic [15:0] value,
    output logic        value_valid,
    output logic [2:0]  digit_count,
    output logic        err,
    output logic        abort
);

    localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam int unsigned CNT_W   = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [15:0]      edit;
    logic [CNT_W-1:0] idle_cnt;

    logic [3:0]  nib;
    logic        is_hex;
    logic        is_bs;
    logic        is_cr;
    logic        is_lf;
    logic        is_esc;
    logic        full;
    logic        timeout_hit;
    logic [15:0] shifted;

    ascii_hex_decode u_decode (
        .ch     (rx_data),
        .nib    (nib),
        .is_hex (is_hex)
    );

    always_comb begin
        is_bs       = (rx_data == ASCII_BS) || (rx_data == ASCII_DEL);
        is_cr       = (rx_data == ASCII_CR);
        is_lf       = (rx_data == ASCII_LF);
        is_esc      = (rx_data == ASCII_ESC);
        full        = (digit_count == 3'd4);
        shifted     = {edit[11:0], nib};
        timeout_hit = TO_EN && (state == EDIT) && !rx_valid && (idle_cnt == TO_LAST);
    end

    // Idle counter: only advances in EDIT, any received byte restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (rx_valid || state != EDIT || timeout_hit) begin
            idle_cnt <= '0;
        end else if (TO_EN && idle_cnt != CNT_MAX) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            edit        <= 16'h0000;
            value       <= 16'h0000;
            word        <= 16'h0000;
            digit_count <= 3'd0;
            value_valid <= 1'b0;
            err         <= 1'b0;
            abort       <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            err         <= 1'b0;
            abort       <= 1'b0;
            if (timeout_hit) begin
                state       <= IDLE;
                edit        <= 16'h0000;
                digit_count <= 3'd0;
                word        <= value;
                abort       <= 1'b1;
            end else if (rx_valid && state == EDIT) begin
                if (is_hex) begin
                    if (full && !OVERWRITE) begin
                        err <= 1'b1;
                    end else begin
                        edit <= shifted;
                        word <= shifted;
                        if (!full) digit_count <= digit_count + 3'd1;
                    end
                end else if (is_bs) begin
                    // An empty buffer has nothing to erase.
                    if (digit_count == 3'd0) begin
                        err <= 1'b1;
                    end else begin
                        edit        <= {4'h0, edit[15:4]};
                        word        <= {4'h0, edit[15:4]};
                        digit_count <= digit_count - 3'd1;
                    end
                end else if (is_cr || is_lf) begin
                    if (digit_count != 3'd0) begin
                        value       <= edit;
                        value_valid <= 1'b1;
                        word        <= edit;
                        state       <= is_cr ? CR_SEEN : IDLE;
                    end else begin
                        word  <= value;
                        state <= IDLE;
                    end
                    edit        <= 16'h0000;
                    digit_count <= 3'd0;
                end else if (is_esc) begin
                    state       <= IDLE;
                    edit        <= 16'h0000;
                    digit_count <= 3'd0;
                    word        <= value;
                    abort       <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end else if (rx_valid) begin
                // IDLE, or CR_SEEN for anything but the LF of a CRLF pair.
                if (state == CR_SEEN && is_lf) begin
                    state <= IDLE;
                end else if (is_hex) begin
                    edit        <= {12'h000, nib};
                    word        <= {12'h000, nib};
                    digit_count <= 3'd1;
                    state       <= EDIT;
                end else if (!(is_cr || is_lf || is_esc)) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule
